fi_writeback_stage: RTL and testbench

Finish (FI) stage that consumes the EX→FI pipeline register outputs and retires one instruction per cycle. It writes results to the register file, updates the architectural status flags, and services loads through a multi-cycle data-memory read handshake. It stalls upstream stages while a load is outstanding or the CPU is halted, and it keeps a retired-instruction counter.

---
 rtl/fi_writeback_stage_pkg.sv | 24 ++
 rtl/fi_writeback_stage_if.sv | 49 ++++
 rtl/fi_writeback_stage_timeout_ctr.sv | 33 +++
 rtl/fi_writeback_stage.sv | 150 +++++++++++++++
 tb/tb_fi_writeback_stage.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/fi_writeback_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fi_pkg
// Description : Opcodes, link register index and FSM states for the FI stage.
// Revision    : 1.0 - initial release
// ============================================================================
package fi_pkg;

    localparam logic [2:0] OP_BL   = 3'b010;
    localparam logic [2:0] OP_LDR  = 3'b011;
    localparam logic [2:0] OP_ALU  = 3'b101;
    localparam logic [2:0] OP_MOV  = 3'b110;
    localparam logic [2:0] OP_HALT = 3'b111;

    localparam logic [2:0] LR = 3'd7;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        LOAD_WAIT = 2'd1,
        HALTED    = 2'd2
    } fi_state_t;

endpackage
`default_nettype wire

// File: rtl/fi_writeback_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : fi_writeback_stage_if
// Description : EX->FI register, data-memory read and register-file bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface fi_writeback_stage_if #(
    parameter int DATA_W = 16,
    parameter int PC_W   = 9
);
    logic              in_valid;
    logic [DATA_W-1:0] ALUoutP;
    logic [2:0]        ZflagsP;
    logic [PC_W-1:0]   PCP;
    logic              loadsPP;
    logic [2:0]        opcodePP;
    logic [2:0]        rdP;

    logic              mem_rd;
    logic [PC_W-1:0]   mem_addr;
    logic              mem_ready;
    logic [DATA_W-1:0] mem_rdata;

    logic              rf_write;
    logic [2:0]        rf_wnum;
    logic [DATA_W-1:0] rf_wdata;
    logic [2:0]        status;
    logic              stall;
    logic              halted;
    logic [15:0]       retired;
    logic              load_err;

    // master: the FI stage itself
    modport master (
        input  in_valid, ALUoutP, ZflagsP, PCP, loadsPP, opcodePP, rdP,
        input  mem_ready, mem_rdata,
        output mem_rd, mem_addr,
        output rf_write, rf_wnum, rf_wdata, status, stall, halted, retired, load_err
    );

    modport slave (
        output in_valid, ALUoutP, ZflagsP, PCP, loadsPP, opcodePP, rdP,
        output mem_ready, mem_rdata,
        input  mem_rd, mem_addr,
        input  rf_write, rf_wnum, rf_wdata, status, stall, halted, retired, load_err
    );

endinterface
`default_nettype wire

// File: rtl/fi_writeback_stage_timeout_ctr.sv
`default_nettype none
// ============================================================================
// Module      : fi_timeout_ctr
// Description : Loadable down-counter; expire_o is high once it reaches zero.
// Revision    : 1.0 - initial release
// ============================================================================
module fi_timeout_ctr #(
    parameter int CNT_W = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             expire_o
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign expire_o = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/fi_writeback_stage.sv
`default_nettype none
// ============================================================================
// Module      : fi_writeback_stage
// Description : Finish stage - register writeback, status flags, load
//               handshake, halt and retired counter. Optional load timeout
//               is built when LOAD_TIMEOUT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module fi_writeback_stage
    import fi_pkg::*;
#(
    parameter int DATA_W         = 16,
    parameter int PC_W           = 9,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fi_writeback_stage_if.master bus
);

    fi_state_t         state_q;
    logic              mem_rd_q;
    logic [PC_W-1:0]   mem_addr_q;
    logic              rf_write_q;
    logic [2:0]        rf_wnum_q;
    logic [DATA_W-1:0] rf_wdata_q;
    logic [2:0]        status_q;
    logic              halted_q;
    logic [15:0]       retired_q;

    logic [15:0]       retired_d;
    logic [DATA_W-1:0] link_d;
    logic              tmo_expire;

    assign retired_d = retired_q + 16'd1;
    assign link_d    = {{(DATA_W-PC_W){1'b0}}, bus.PCP};

`ifdef LOAD_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic load_err_q;

    // Reloaded every cycle outside LOAD_WAIT so a fresh load starts a full window
    fi_timeout_ctr #(
        .CNT_W (CNT_W)
    ) u_timeout_ctr (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (state_q != LOAD_WAIT),
        .load_val_i (CNT_W'(TIMEOUT_CYCLES - 1)),
        .dec_i      ((state_q == LOAD_WAIT) && !bus.mem_ready),
        .expire_o   (tmo_expire)
    );

    assign bus.load_err = load_err_q;
`else
    assign tmo_expire   = 1'b0;
    assign bus.load_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RUN;
            mem_rd_q   <= 1'b0;
            mem_addr_q <= '0;
            rf_write_q <= 1'b0;
            rf_wnum_q  <= '0;
            rf_wdata_q <= '0;
            status_q   <= '0;
            halted_q   <= 1'b0;
            retired_q  <= '0;
`ifdef LOAD_TIMEOUT_EN
            load_err_q <= 1'b0;
`endif
        end else begin
            rf_write_q <= 1'b0;
`ifdef LOAD_TIMEOUT_EN
            load_err_q <= 1'b0;
`endif
            case (state_q)
                RUN: begin
                    if (bus.in_valid) begin
                        // A load defers retirement until its data is accepted
                        if (bus.loadsPP) begin
                            mem_addr_q <= bus.ALUoutP[PC_W-1:0];
                            rf_wnum_q  <= bus.rdP;
                            mem_rd_q   <= 1'b1;
                            state_q    <= LOAD_WAIT;
                        end else begin
                            retired_q <= retired_d;
                            case (bus.opcodePP)
                                OP_ALU: begin
                                    rf_write_q <= 1'b1;
                                    rf_wnum_q  <= bus.rdP;
                                    rf_wdata_q <= bus.ALUoutP;
                                    status_q   <= bus.ZflagsP;
                                end
                                OP_MOV: begin
                                    rf_write_q <= 1'b1;
                                    rf_wnum_q  <= bus.rdP;
                                    rf_wdata_q <= bus.ALUoutP;
                                end
                                OP_BL: begin
                                    rf_write_q <= 1'b1;
                                    rf_wnum_q  <= LR;
                                    rf_wdata_q <= link_d;
                                end
                                OP_HALT: begin
                                    halted_q <= 1'b1;
                                    state_q  <= HALTED;
                                end
                                default: ;
                            endcase
                        end
                    end
                end
                LOAD_WAIT: begin
                    if (bus.mem_ready) begin
                        rf_write_q <= 1'b1;
                        rf_wdata_q <= bus.mem_rdata;
                        mem_rd_q   <= 1'b0;
                        retired_q  <= retired_d;
                        state_q    <= RUN;
                    end else if (tmo_expire) begin
`ifdef LOAD_TIMEOUT_EN
                        load_err_q <= 1'b1;
`endif
                        mem_rd_q   <= 1'b0;
                        retired_q  <= retired_d;
                        state_q    <= RUN;
                    end
                end
                HALTED: ;
                default: state_q <= RUN;
            endcase
        end
    end

    assign bus.stall    = (state_q != RUN);
    assign bus.mem_rd   = mem_rd_q;
    assign bus.mem_addr = mem_addr_q;
    assign bus.rf_write = rf_write_q;
    assign bus.rf_wnum  = rf_wnum_q;
    assign bus.rf_wdata = rf_wdata_q;
    assign bus.status   = status_q;
    assign bus.halted   = halted_q;
    assign bus.retired  = retired_q;

endmodule
`default_nettype wire

// File: tb/tb_fi_writeback_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_fi_writeback_stage
// Description : Directed vector table plus load, reset, halt and wrap sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fi_writeback_stage;
    import fi_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fi_writeback_stage_if #(.DATA_W(16), .PC_W(9)) bus ();

    fi_writeback_stage #(
        .DATA_W         (16),
        .PC_W           (9),
        .TIMEOUT_CYCLES (64)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic        v;
        logic [2:0]  op;
        logic [15:0] alu;
        logic [2:0]  z;
        logic [8:0]  pc;
        logic [2:0]  rd;
        logic        ew;
        logic [2:0]  ewn;
        logic [15:0] ewd;
        logic [2:0]  est;
        logic [15:0] eret;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic ld, input logic [2:0] op,
                         input logic [15:0] alu, input logic [2:0] z,
                         input logic [8:0] pc, input logic [2:0] rd);
        bus.in_valid = v;
        bus.loadsPP  = ld;
        bus.opcodePP = op;
        bus.ALUoutP  = alu;
        bus.ZflagsP  = z;
        bus.PCP      = pc;
        bus.rdP      = rd;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 3'b000, 16'h0, 3'b000, 9'h0, 3'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        idle();
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 16'h0;

        //             v  op       alu       z       pc      rd    ew ewn   ewd       est     eret
        tbl[0] = '{1'b1, OP_ALU,  16'h00A5, 3'b010, 9'h000, 3'd3, 1'b1, 3'd3, 16'h00A5, 3'b010, 16'd1};
        tbl[1] = '{1'b1, OP_MOV,  16'h1234, 3'b111, 9'h000, 3'd5, 1'b1, 3'd5, 16'h1234, 3'b010, 16'd2};
        tbl[2] = '{1'b1, OP_ALU,  16'h0000, 3'b100, 9'h000, 3'd0, 1'b1, 3'd0, 16'h0000, 3'b100, 16'd3};
        tbl[3] = '{1'b0, OP_ALU,  16'hFFFF, 3'b001, 9'h000, 3'd6, 1'b0, 3'd0, 16'h0000, 3'b100, 16'd3};
        tbl[4] = '{1'b1, 3'b000,  16'h7777, 3'b111, 9'h000, 3'd2, 1'b0, 3'd0, 16'h0000, 3'b100, 16'd4};
        tbl[5] = '{1'b1, OP_LDR,  16'h3333, 3'b111, 9'h000, 3'd2, 1'b0, 3'd0, 16'h0000, 3'b100, 16'd5};
        tbl[6] = '{1'b1, OP_BL,   16'hFFFF, 3'b111, 9'h123, 3'd2, 1'b1, 3'd7, 16'h0123, 3'b100, 16'd6};
        tbl[7] = '{1'b1, OP_ALU,  16'h8001, 3'b011, 9'h000, 3'd1, 1'b1, 3'd1, 16'h8001, 3'b011, 16'd7};
        tbl[8] = '{1'b1, 3'b001,  16'h4444, 3'b000, 9'h000, 3'd4, 1'b0, 3'd1, 16'h8001, 3'b011, 16'd8};
        tbl[9] = '{1'b1, OP_MOV,  16'hFFFF, 3'b000, 9'h000, 3'd7, 1'b1, 3'd7, 16'hFFFF, 3'b011, 16'd9};

        // Reset state
        do_reset();
        chk("rst_mem_rd",   32'(bus.mem_rd),   32'h0);
        chk("rst_mem_addr", 32'(bus.mem_addr), 32'h0);
        chk("rst_rf_write", 32'(bus.rf_write), 32'h0);
        chk("rst_rf_wnum",  32'(bus.rf_wnum),  32'h0);
        chk("rst_rf_wdata", 32'(bus.rf_wdata), 32'h0);
        chk("rst_status",   32'(bus.status),   32'h0);
        chk("rst_halted",   32'(bus.halted),   32'h0);
        chk("rst_retired",  32'(bus.retired),  32'h0);
        chk("rst_load_err", 32'(bus.load_err), 32'h0);
        chk("rst_stall",    32'(bus.stall),    32'h0);

        // Back-to-back single-cycle instructions
        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].v, 1'b0, tbl[i].op, tbl[i].alu, tbl[i].z, tbl[i].pc, tbl[i].rd);
            tick();
            chk($sformatf("vec%0d_write", i),   32'(bus.rf_write), 32'(tbl[i].ew));
            chk($sformatf("vec%0d_wnum", i),    32'(bus.rf_wnum),  32'(tbl[i].ewn));
            chk($sformatf("vec%0d_wdata", i),   32'(bus.rf_wdata), 32'(tbl[i].ewd));
            chk($sformatf("vec%0d_status", i),  32'(bus.status),   32'(tbl[i].est));
            chk($sformatf("vec%0d_retired", i), 32'(bus.retired),  32'(tbl[i].eret));
            chk($sformatf("vec%0d_stall", i),   32'(bus.stall),    32'h0);
        end

        // Load from 0x1F, data arrives on the third wait cycle
        drive(1'b1, 1'b1, OP_LDR, 16'hFE1F, 3'b000, 9'h0, 3'd4);
        tick();
        drive(1'b1, 1'b0, OP_ALU, 16'hDEAD, 3'b101, 9'h0, 3'd2);
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("ld_stall%0d", c),  32'(bus.stall),    32'h1);
            chk($sformatf("ld_mem_rd%0d", c), 32'(bus.mem_rd),   32'h1);
            chk($sformatf("ld_addr%0d", c),   32'(bus.mem_addr), 32'h01F);
            chk($sformatf("ld_nowr%0d", c),   32'(bus.rf_write), 32'h0);
            if (c == 2) begin
                bus.mem_ready = 1'b1;
                bus.mem_rdata = 16'hBEEF;
            end
            tick();
        end
        bus.mem_ready = 1'b0;
        chk("ld_write",   32'(bus.rf_write), 32'h1);
        chk("ld_wnum",    32'(bus.rf_wnum),  32'h4);
        chk("ld_wdata",   32'(bus.rf_wdata), 32'hBEEF);
        chk("ld_stall",   32'(bus.stall),    32'h0);
        chk("ld_mem_rd",  32'(bus.mem_rd),   32'h0);
        chk("ld_retired", 32'(bus.retired),  32'd10);
        chk("ld_status",  32'(bus.status),   32'b011);
        drive(1'b1, 1'b0, OP_MOV, 16'h5555, 3'b000, 9'h0, 3'd2);
        tick();
        chk("mov_write",   32'(bus.rf_write), 32'h1);
        chk("mov_wnum",    32'(bus.rf_wnum),  32'h2);
        chk("mov_wdata",   32'(bus.rf_wdata), 32'h5555);
        chk("mov_retired", 32'(bus.retired),  32'd11);
        idle();
        tick();
        chk("mov_pulse", 32'(bus.rf_write), 32'h0);

        // Asynchronous reset while a read is outstanding
        drive(1'b1, 1'b1, OP_LDR, 16'h00AB, 3'b000, 9'h0, 3'd1);
        tick();
        idle();
        tick();
        chk("mid_mem_rd", 32'(bus.mem_rd), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_mem_rd",  32'(bus.mem_rd),   32'h0);
        chk("arst_stall",   32'(bus.stall),    32'h0);
        chk("arst_write",   32'(bus.rf_write), 32'h0);
        chk("arst_retired", 32'(bus.retired),  32'h0);
        chk("arst_addr",    32'(bus.mem_addr), 32'h0);
        tick();
        rst_n = 1'b1;
        drive(1'b1, 1'b0, OP_MOV, 16'h0042, 3'b000, 9'h0, 3'd6);
        tick();
        chk("post_rst_write",   32'(bus.rf_write), 32'h1);
        chk("post_rst_wnum",    32'(bus.rf_wnum),  32'h6);
        chk("post_rst_retired", 32'(bus.retired),  32'd1);
        idle();
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 16'h9999;
        tick();
        bus.mem_ready = 1'b0;
        chk("stray_ready_write",   32'(bus.rf_write), 32'h0);
        chk("stray_ready_retired", 32'(bus.retired),  32'd1);

`ifdef LOAD_TIMEOUT_EN
        begin
            int k;
            drive(1'b1, 1'b1, OP_LDR, 16'h0010, 3'b000, 9'h0, 3'd5);
            tick();
            idle();
            k = 0;
            while (k < 200 && bus.load_err !== 1'b1) begin
                tick();
                k++;
            end
            chk("tmo_cycles",  32'(k),            32'd64);
            chk("tmo_nowrite", 32'(bus.rf_write), 32'h0);
            chk("tmo_stall",   32'(bus.stall),    32'h0);
            chk("tmo_mem_rd",  32'(bus.mem_rd),   32'h0);
            chk("tmo_retired", 32'(bus.retired),  32'd2);
            tick();
            chk("tmo_pulse",   32'(bus.load_err), 32'h0);
        end
`else
        drive(1'b1, 1'b1, OP_LDR, 16'h0010, 3'b000, 9'h0, 3'd5);
        tick();
        idle();
        repeat (100) tick();
        chk("wait_stall",    32'(bus.stall),    32'h1);
        chk("wait_mem_rd",   32'(bus.mem_rd),   32'h1);
        chk("wait_load_err", 32'(bus.load_err), 32'h0);
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 16'h0777;
        tick();
        bus.mem_ready = 1'b0;
        chk("late_write",   32'(bus.rf_write), 32'h1);
        chk("late_wdata",   32'(bus.rf_wdata), 32'h0777);
        chk("late_retired", 32'(bus.retired),  32'd2);
`endif

        // BL then HALT; later instructions are ignored
        drive(1'b1, 1'b0, OP_BL, 16'hAAAA, 3'b111, 9'h123, 3'd3);
        tick();
        chk("bl_write",   32'(bus.rf_write), 32'h1);
        chk("bl_wnum",    32'(bus.rf_wnum),  32'h7);
        chk("bl_wdata",   32'(bus.rf_wdata), 32'h0123);
        chk("bl_status",  32'(bus.status),   32'h0);
        chk("bl_retired", 32'(bus.retired),  32'd3);
        drive(1'b1, 1'b0, OP_HALT, 16'h0, 3'b000, 9'h0, 3'd0);
        tick();
        chk("halt_halted",  32'(bus.halted),   32'h1);
        chk("halt_stall",   32'(bus.stall),    32'h1);
        chk("halt_retired", 32'(bus.retired),  32'd4);
        chk("halt_write",   32'(bus.rf_write), 32'h0);
        drive(1'b1, 1'b0, OP_ALU, 16'h1111, 3'b111, 9'h0, 3'd1);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk($sformatf("hold%0d_write", c),   32'(bus.rf_write), 32'h0);
            chk($sformatf("hold%0d_retired", c), 32'(bus.retired),  32'd4);
            chk($sformatf("hold%0d_status", c),  32'(bus.status),   32'h0);
            chk($sformatf("hold%0d_stall", c),   32'(bus.stall),    32'h1);
        end

        // Retired counter wrap
        idle();
        do_reset();
        drive(1'b1, 1'b0, 3'b000, 16'h0, 3'b000, 9'h0, 3'd0);
        repeat (65535) tick();
        chk("wrap_max",  32'(bus.retired), 32'hFFFF);
        tick();
        chk("wrap_zero", 32'(bus.retired), 32'h0);
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
